// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: arbitrates load-use, branch and mul/div requests
// into per-stage write enables, bubble/flush strobes and a delayed WB-forward select.
module pipeline_stall_controller #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load_use_stall,
    input  logic             fwd_wb_rs1,
    input  logic             fwd_wb_rs2,
    input  logic             branch_taken,
    input  logic             muldiv_start,
    input  logic             muldiv_done,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             id_ex_write_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             fwd_sel_rs1,
    output logic             fwd_sel_rs2,
    output logic             md_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       dbg_state_o
);

    localparam int unsigned     MD_W    = $clog2(MD_TIMEOUT + 1);
    localparam logic [MD_W-1:0] MD_LAST = MD_W'(MD_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MD_BUSY    = 2'd2,
        ST_FLUSH      = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              pend_lu_q, pend_lu_d;
    logic              rs1_q, rs1_d;
    logic              rs2_q, rs2_d;
    logic [MD_W-1:0]   md_cnt_q, md_cnt_d, md_cnt_inc;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              fwd1_q, fwd1_d;
    logic              fwd2_q, fwd2_d;
    logic              pc_en_q, pc_en_d;
    logic              ifid_en_q, ifid_en_d;
    logic              idex_en_q, idex_en_d;
    logic              flush_q, flush_d;
    logic              idbub_q, idbub_d;
    logic              exbub_q, exbub_d;

    assign md_cnt_inc = md_cnt_q + MD_W'(1);

    always_comb begin
        state_d   = state_q;
        pend_lu_d = pend_lu_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        md_cnt_d  = md_cnt_q;
        err_d     = err_q;
        fwd1_d    = 1'b0;
        fwd2_d    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    state_d = ST_FLUSH;
                end else if (muldiv_start) begin
                    state_d   = ST_MD_BUSY;
                    md_cnt_d  = '0;
                    pend_lu_d = 1'b0;
                end else if (load_use_stall) begin
                    state_d = ST_LOAD_STALL;
                    rs1_d   = fwd_wb_rs1;
                    rs2_d   = fwd_wb_rs2;
                end
            end
            ST_LOAD_STALL: begin
                // Captured forward flags are consumed here; a branch flush discards them.
                rs1_d = 1'b0;
                rs2_d = 1'b0;
                if (branch_taken) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                    fwd1_d  = rs1_q;
                    fwd2_d  = rs2_q;
                end
            end
            ST_MD_BUSY: begin
                md_cnt_d = md_cnt_inc;
                if (load_use_stall) begin
                    pend_lu_d = 1'b1;
                    rs1_d     = fwd_wb_rs1;
                    rs2_d     = fwd_wb_rs2;
                end
                // EX is held, so branch_taken cannot be acted on while busy.
                if (muldiv_done || (md_cnt_inc == MD_LAST)) begin
                    if (!muldiv_done) begin
                        err_d = 1'b1;
                    end
                    state_d   = (pend_lu_q || load_use_stall) ? ST_LOAD_STALL : ST_RUN;
                    pend_lu_d = 1'b0;
                    md_cnt_d  = '0;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet still Moore.
    always_comb begin
        pc_en_d   = !((state_d == ST_LOAD_STALL) || (state_d == ST_MD_BUSY));
        ifid_en_d = !((state_d == ST_LOAD_STALL) || (state_d == ST_MD_BUSY));
        idex_en_d = (state_d != ST_MD_BUSY);
        flush_d   = (state_d == ST_FLUSH);
        idbub_d   = (state_d == ST_LOAD_STALL) || (state_d == ST_FLUSH);
        exbub_d   = (state_d == ST_MD_BUSY);
        if (!pc_en_q && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_RUN;
            pend_lu_q   <= 1'b0;
            rs1_q       <= 1'b0;
            rs2_q       <= 1'b0;
            md_cnt_q    <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            fwd1_q      <= 1'b0;
            fwd2_q      <= 1'b0;
            pc_en_q     <= 1'b1;
            ifid_en_q   <= 1'b1;
            idex_en_q   <= 1'b1;
            flush_q     <= 1'b0;
            idbub_q     <= 1'b0;
            exbub_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_lu_q   <= pend_lu_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            md_cnt_q    <= md_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            fwd1_q      <= fwd1_d;
            fwd2_q      <= fwd2_d;
            pc_en_q     <= pc_en_d;
            ifid_en_q   <= ifid_en_d;
            idex_en_q   <= idex_en_d;
            flush_q     <= flush_d;
            idbub_q     <= idbub_d;
            exbub_q     <= exbub_d;
        end
    end

    assign pc_write_en    = pc_en_q;
    assign if_id_write_en = ifid_en_q;
    assign id_ex_write_en = idex_en_q;
    assign if_id_flush    = flush_q;
    assign id_ex_bubble   = idbub_q;
    assign ex_mem_bubble  = exbub_q;
    assign fwd_sel_rs1    = fwd1_q;
    assign fwd_sel_rs2    = fwd2_q;
    assign md_timeout_err = err_q;
    assign stall_cycles   = stall_cnt_q;
    assign dbg_state_o    = state_q;

endmodule
